// File: rtl/muldiv_unit_if.sv
// Request/write-back bundle between the core issue logic and muldiv_unit.
// master = core side (issues ops, receives write-back), slave = the unit.
interface muldiv_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  rd_addr;
  logic        busy;
  logic        done;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg_addr;
  logic        wb_write_en;
  logic        illegal_op;

  modport master (
    output start, op, operand_a, operand_b, rd_addr,
    input  busy, done, wb_data, wb_reg_addr, wb_write_en, illegal_op
  );

  modport slave (
    input  start, op, operand_a, operand_b, rd_addr,
    output busy, done, wb_data, wb_reg_addr, wb_write_en, illegal_op
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add / restoring divide.
// Define MULDIV_DIV_EN to build the divider; otherwise divide ops flag illegal_op.
module muldiv_unit (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned PW    = 2 * XLEN;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned RW    = 5;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [RW-1:0]     rd_q, rd_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   opb_q, opb_d, acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic [RW-1:0]     wb_reg_addr_q, wb_reg_addr_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              wb_write_en_q, wb_write_en_d, illegal_op_q, illegal_op_d;

  logic              signed_a, signed_b, sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              special;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   step_hi, step_lo, result;
  logic [PW-1:0]     prod, prod_s;
`ifdef MULDIV_DIV_EN
  logic [XLEN:0]     div_shift, div_diff;
  logic [XLEN-1:0]   div_val;
`endif

  // Operand signedness and magnitudes for the incoming request
  always_comb begin
    signed_a = (bus.op == 3'b001) || (bus.op == 3'b010) || (bus.op == 3'b100) || (bus.op == 3'b110);
    signed_b = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
    sign_a   = signed_a & bus.operand_a[XLEN-1];
    sign_b   = signed_b & bus.operand_b[XLEN-1];
    mag_a    = sign_a ? XLEN'(-bus.operand_a) : bus.operand_a;
    mag_b    = sign_b ? XLEN'(-bus.operand_b) : bus.operand_b;
`ifdef MULDIV_DIV_EN
    special     = bus.op[2] && ((bus.operand_b == '0) ||
                  (!bus.op[0] && bus.operand_a == 32'h8000_0000 && bus.operand_b == 32'hFFFF_FFFF));
    if (bus.operand_b == '0)
      special_res = bus.op[1] ? bus.operand_a : 32'hFFFF_FFFF;
    else
      special_res = bus.op[1] ? 32'h0 : 32'h8000_0000;
`else
    special     = bus.op[2];
    special_res = '0;
`endif
  end

  // One iteration: hi:lo holds partial product or remainder:quotient
  always_comb begin
    mul_sum = {1'b0, acc_hi_q} + ({1'b0, opb_q} & {(XLEN+1){acc_lo_q[0]}});
    step_hi = mul_sum[XLEN:1];
    step_lo = {mul_sum[0], acc_lo_q[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    if (op_q[2]) begin
      if (!div_diff[XLEN]) begin
        step_hi = div_diff[XLEN-1:0];
        step_lo = {acc_lo_q[XLEN-2:0], 1'b1};
      end else begin
        step_hi = div_shift[XLEN-1:0];
        step_lo = {acc_lo_q[XLEN-2:0], 1'b0};
      end
    end
`endif
  end

  // Final result from the last iteration's values, sign applied
  always_comb begin
    prod   = {step_hi, step_lo};
    prod_s = neg_q ? PW'(-prod) : prod;
    result = (op_q == 3'b000) ? prod_s[XLEN-1:0] : prod_s[PW-1:XLEN];
`ifdef MULDIV_DIV_EN
    div_val = op_q[1] ? step_hi : step_lo;
    if (op_q[2]) result = neg_q ? XLEN'(-div_val) : div_val;
`endif
  end

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    rd_d          = rd_q;
    neg_d         = neg_q;
    opb_d         = opb_q;
    acc_hi_d      = acc_hi_q;
    acc_lo_d      = acc_lo_q;
    wb_data_d     = wb_data_q;
    wb_reg_addr_d = wb_reg_addr_q;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    wb_write_en_d = 1'b0;
    illegal_op_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          op_d     = bus.op;
          rd_d     = bus.rd_addr;
          cnt_d    = '0;
          acc_hi_d = '0;
          acc_lo_d = mag_b;
          opb_d    = mag_a;
          neg_d    = sign_a ^ sign_b;
`ifdef MULDIV_DIV_EN
          if (bus.op[2]) begin
            acc_lo_d = mag_a;
            opb_d    = mag_b;
            neg_d    = bus.op[1] ? sign_a : (sign_a ^ sign_b);
          end
`endif
          if (special) begin
            state_d       = DONE;
            done_d        = 1'b1;
            wb_data_d     = special_res;
            wb_reg_addr_d = bus.rd_addr;
`ifdef MULDIV_DIV_EN
            wb_write_en_d = (bus.rd_addr != '0);
`else
            illegal_op_d  = 1'b1;
`endif
          end else begin
            state_d = CALC;
            busy_d  = 1'b1;
          end
        end
      end
      CALC: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d       = DONE;
          done_d        = 1'b1;
          wb_data_d     = result;
          wb_reg_addr_d = rd_q;
          wb_write_en_d = (rd_q != '0);
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      rd_q          <= '0;
      neg_q         <= 1'b0;
      opb_q         <= '0;
      acc_hi_q      <= '0;
      acc_lo_q      <= '0;
      wb_data_q     <= '0;
      wb_reg_addr_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      wb_write_en_q <= 1'b0;
      illegal_op_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      rd_q          <= rd_d;
      neg_q         <= neg_d;
      opb_q         <= opb_d;
      acc_hi_q      <= acc_hi_d;
      acc_lo_q      <= acc_lo_d;
      wb_data_q     <= wb_data_d;
      wb_reg_addr_q <= wb_reg_addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      wb_write_en_q <= wb_write_en_d;
      illegal_op_q  <= illegal_op_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_reg_addr = wb_reg_addr_q;
  assign bus.wb_write_en = wb_write_en_q;
  assign bus.illegal_op  = illegal_op_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes expected write-backs,
// a negedge monitor pops and compares them (data, address, enable, flag, cycle).
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        we;
    logic        ill;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  muldiv_unit_if bus();

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=%h expected=none", bus.wb_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_data", bus.wb_data, e.data);
        chk("wb_reg_addr", 32'(bus.wb_reg_addr), 32'(e.addr));
        chk("wb_write_en", 32'(bus.wb_write_en), 32'(e.we));
        chk("illegal_op", 32'(bus.illegal_op), 32'(e.ill));
        chk("done_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Drive one request starting at a negedge; returns just after the accepting edge
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [31:0] exp_data,
                      input bit special, input bit ill, input bit push);
    exp_t e;
    bus.start = 1'b1;
    bus.op = op;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.rd_addr = rd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op = 3'($urandom);
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
    bus.rd_addr = 5'($urandom);
    if (push) begin
      e.data = ill ? 32'h0 : exp_data;
      e.addr = rd;
      e.we   = (rd != 5'd0) && !ill;
      e.ill  = ill;
      e.due  = cyc + (special ? 0 : 32);
      exp_q.push_back(e);
    end
    chk("busy_after_accept", 32'(bus.busy), special ? 32'd0 : 32'd1);
  endtask

  task automatic send_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_data, input bit special);
`ifdef MULDIV_DIV_EN
    send(op, a, b, rd, exp_data, special, 1'b0, 1'b1);
`else
    send(op, a, b, rd, 32'h0, 1'b1, 1'b1, 1'b1);
`endif
  endtask

  // Leaves the caller at the negedge inside the done cycle
  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk("done_within_budget", 32'(seen), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    bus.start = 1'b0;
    bus.op = 3'b000;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'h0);
    chk("rst_wb_reg_addr", 32'(bus.wb_reg_addr), 32'd0);
    chk("rst_wb_write_en", 32'(bus.wb_write_en), 32'd0);
    chk("rst_illegal_op", 32'(bus.illegal_op), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Multiplies, then hold check in idle
    send(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);
    chk("hold_wb_data", bus.wb_data, 32'hFFFF_FFEB);
    chk("hold_wb_reg_addr", 32'(bus.wb_reg_addr), 32'd5);
    chk("idle_done", 32'(bus.done), 32'd0);
    chk("idle_wb_write_en", 32'(bus.wb_write_en), 32'd0);

    send(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    wait_done();
    send(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    wait_done();
    send(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    wait_done();
    send(3'b000, 32'd3, 32'd4, 5'd9, 32'd12, 1'b0, 1'b0, 1'b1);
    wait_done();
    send(3'b000, 32'd5, 32'd6, 5'd0, 32'd30, 1'b0, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);

    // Divides and special cases, back to back
    send_div(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 1'b0);
    wait_done();
    send_div(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 1'b0);
    wait_done();
    send_div(3'b101, 32'd100, 32'd7, 5'd12, 32'd14, 1'b0);
    wait_done();
    send_div(3'b111, 32'd100, 32'd7, 5'd13, 32'd2, 1'b0);
    wait_done();
    send_div(3'b101, 32'd100, 32'd0, 5'd14, 32'hFFFF_FFFF, 1'b1);
    wait_done();
    send_div(3'b111, 32'd100, 32'd0, 5'd15, 32'd100, 1'b1);
    wait_done();
    send_div(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1'b1);
    wait_done();
    send_div(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0, 1'b1);
    wait_done();
    send_div(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h0, 1'b0);
    wait_done();
    send_div(3'b101, 32'd10, 32'd3, 5'd19, 32'd3, 1'b0);
    wait_done();
    @(negedge clk);

    // Start pulsed mid-computation is ignored
    send(3'b000, 32'h1234_5678, 32'h10, 5'd20, 32'h2345_6780, 1'b0, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 3'b011;
    bus.operand_a = 32'hFFFF_FFFF;
    bus.operand_b = 32'hFFFF_FFFF;
    bus.rd_addr = 5'd31;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done();
    @(negedge clk);

    // Reset mid-computation aborts without a done pulse
    send(3'b000, 32'd9, 32'd9, 5'd21, 32'd81, 1'b0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);

    send(3'b000, 32'h0000_FFFF, 32'h0001_0001, 5'd22, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    wait_done();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
